// File: rtl/ccr_stack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccr_stack_if : flag, jump and save/restore signals of ccr_stack_unit     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface ccr_stack_if;
  logic [2:0] flagIn;
  logic       flagWrite;
  logic       stall;
  logic       jmpValid;
  logic [1:0] jmpType;
  logic       push;
  logic       pop;
  logic [2:0] ccr;
  logic       taken;
  logic [2:0] stackCount;
  logic       overflow;
  logic       underflow;

  modport master (
    output flagIn, flagWrite, stall, jmpValid, jmpType, push, pop,
    input  ccr, taken, stackCount, overflow, underflow
  );

  modport slave (
    input  flagIn, flagWrite, stall, jmpValid, jmpType, push, pop,
    output ccr, taken, stackCount, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/ccr_stack_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccr_stack_unit : condition-code register with LIFO save slots and jumps  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ccr_stack_unit #(
  parameter int STACK_DEPTH = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ccr_stack_if.slave  bus
);

  logic [2:0] ccr_q,   ccr_d;
  logic [2:0] count_q, count_d;
  logic       ovf_q,   ovf_d;
  logic       unf_q,   unf_d;
  logic [2:0] stack_q [STACK_DEPTH];
  logic [2:0] stack_d [STACK_DEPTH];

  logic       flag_sel;
  logic [2:0] clr_mask;
  logic       taken_w;
  logic [2:0] top_slot;

  // ccr layout is {N,C,Z}; jmpType 01 tests Z, 10 tests N, 11 tests C
  always_comb begin
    flag_sel = 1'b0;
    clr_mask = 3'b000;
    case (bus.jmpType)
      2'b01:   begin flag_sel = ccr_q[0]; clr_mask = 3'b001; end
      2'b10:   begin flag_sel = ccr_q[2]; clr_mask = 3'b100; end
      2'b11:   begin flag_sel = ccr_q[1]; clr_mask = 3'b010; end
      default: begin flag_sel = 1'b0;     clr_mask = 3'b000; end
    endcase
  end

  assign taken_w = bus.jmpValid & ~bus.stall & (bus.jmpType != 2'b00) & flag_sel;

  always_comb begin
    top_slot = 3'b000;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == 3'(i + 1)) top_slot = stack_q[i];
    end
  end

  always_comb begin
    ccr_d   = ccr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];

    if (!bus.stall) begin
      if (bus.pop) begin
        // a pop owns the cycle: push, flagWrite and jump-clear are dropped
        if (count_q != 3'd0) begin
          ccr_d   = top_slot;
          count_d = count_q - 3'd1;
        end else begin
          unf_d = 1'b1;
        end
      end else begin
        if (bus.push) begin
          if (count_q < 3'(STACK_DEPTH)) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (count_q == 3'(i)) stack_d[i] = ccr_q;
            end
            count_d = count_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.flagWrite)  ccr_d = bus.flagIn;
        else if (taken_w)   ccr_d = ccr_q & ~clr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_q   <= 3'b000;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 3'b000;
    end else begin
      ccr_q   <= ccr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.ccr        = ccr_q;
  assign bus.taken      = taken_w;
  assign bus.stackCount = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;

endmodule
`default_nettype wire
